hazard_ctrl_unit: RTL and testbench

Parametrised pipeline hazard controller for the 5-stage RISC-V core. It replaces the purely combinational load-use detector with a registered controller. It covers:
- multi-cycle load-use stalls (configurable load-to-use latency), honouring x0 and operand-use qualifiers;
- taken-branch flush;
- global freeze while data memory is not ready;
- a saturating stall-cycle performance counter.

It sits in the ID stage and drives PC, IF/ID and ID/EX control.

---
 rtl/hazard_ctrl_unit.sv | 119 +++++++++++
 tb/tb_hazard_ctrl_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
// hazard_ctrl_unit : registered load-use / branch / mem-busy hazard controller
// Revision: 1.0
// ============================================================================
module hazard_ctrl_unit #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              idex_memread,
  input  logic [REG_AW-1:0] idex_rd,
  input  logic [REG_AW-1:0] ifid_rs1,
  input  logic [REG_AW-1:0] ifid_rs2,
  input  logic              ifid_use_rs1,
  input  logic              ifid_use_rs2,
  input  logic              branch_taken,
  input  logic              mem_busy,
  input  logic              perf_clr,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              ctrl_en,
  output logic              pipe_freeze,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int c_LW = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);

  localparam logic [0:0] c_IDLE     = 1'b0;
  localparam logic [0:0] c_LU_STALL = 1'b1;

  localparam logic [c_LW-1:0] c_LAT_RELOAD = c_LW'(LOAD_LAT - 1);
  localparam logic [c_LW-1:0] c_ONE        = c_LW'(1);

  logic [0:0]      r_state;
  logic [0:0]      w_next_state;
  logic [c_LW-1:0] r_lat_cnt;
  logic [c_LW-1:0] w_next_cnt;
  logic [CNT_W-1:0] r_stall_count;

  logic w_hz;
  logic w_pc_write;
  logic w_ifid_write;
  logic w_ifid_flush;
  logic w_ctrl_en;
  logic w_pipe_freeze;

  assign w_hz = idex_memread && (idex_rd != '0) &&
                ((ifid_use_rs1 && (idex_rd == ifid_rs1)) ||
                 (ifid_use_rs2 && (idex_rd == ifid_rs2)));

  always_comb begin
    w_next_state  = r_state;
    w_next_cnt    = r_lat_cnt;
    w_pc_write    = 1'b1;
    w_ifid_write  = 1'b1;
    w_ifid_flush  = 1'b0;
    w_ctrl_en     = 1'b1;
    w_pipe_freeze = 1'b0;

    if (mem_busy) begin
      // Memory stall holds everything, including the bubble counter.
      w_pc_write    = 1'b0;
      w_ifid_write  = 1'b0;
      w_pipe_freeze = 1'b1;
    end else if (branch_taken) begin
      // Dependent instruction is squashed, so any pending stall is dropped.
      w_ifid_flush = 1'b1;
      w_ctrl_en    = 1'b0;
      w_next_state = c_IDLE;
      w_next_cnt   = '0;
    end else if (r_state == c_LU_STALL) begin
      w_pc_write   = 1'b0;
      w_ifid_write = 1'b0;
      w_ctrl_en    = 1'b0;
      w_next_cnt   = r_lat_cnt - c_ONE;
      if (r_lat_cnt == c_ONE) begin
        w_next_state = c_IDLE;
      end
    end else if (w_hz) begin
      w_pc_write   = 1'b0;
      w_ifid_write = 1'b0;
      w_ctrl_en    = 1'b0;
      if (LOAD_LAT > 1) begin
        w_next_state = c_LU_STALL;
        w_next_cnt   = c_LAT_RELOAD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= c_IDLE;
      r_lat_cnt     <= '0;
      r_stall_count <= '0;
    end else begin
      r_state   <= w_next_state;
      r_lat_cnt <= w_next_cnt;
      if (perf_clr) begin
        r_stall_count <= '0;
      end else if (!w_pc_write && (r_stall_count != {CNT_W{1'b1}})) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
    end
  end

  // Reset overrides the datapath controls so the front end loads NOPs.
  assign pc_write    = rst_n && w_pc_write;
  assign ifid_write  = rst_n && w_ifid_write;
  assign ifid_flush  = !rst_n || w_ifid_flush;
  assign ctrl_en     = rst_n && w_ctrl_en;
  assign pipe_freeze = rst_n && w_pipe_freeze;
  assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_unit.sv
`default_nettype none
// Scoreboard bench: two controllers (LOAD_LAT=1 and LOAD_LAT=3, 4-bit counter)
// share stimulus; expected outputs are queued per cycle and checked by a monitor.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       idex_memread = 1'b0;
  logic [4:0] idex_rd = '0;
  logic [4:0] ifid_rs1 = '0;
  logic [4:0] ifid_rs2 = '0;
  logic       ifid_use_rs1 = 1'b0;
  logic       ifid_use_rs2 = 1'b0;
  logic       branch_taken = 1'b0;
  logic       mem_busy = 1'b0;
  logic       perf_clr = 1'b0;

  logic       pcw1, ifw1, fl1, cen1, frz1;
  logic       pcw3, ifw3, fl3, cen3, frz3;
  logic [3:0] cnt1, cnt3;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(4)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_use_rs1(ifid_use_rs1),
    .ifid_use_rs2(ifid_use_rs2), .branch_taken(branch_taken), .mem_busy(mem_busy),
    .perf_clr(perf_clr), .pc_write(pcw1), .ifid_write(ifw1), .ifid_flush(fl1),
    .ctrl_en(cen1), .pipe_freeze(frz1), .stall_count(cnt1)
  );

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(4)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_use_rs1(ifid_use_rs1),
    .ifid_use_rs2(ifid_use_rs2), .branch_taken(branch_taken), .mem_busy(mem_busy),
    .perf_clr(perf_clr), .pc_write(pcw3), .ifid_write(ifw3), .ifid_flush(fl3),
    .ctrl_en(cen3), .pipe_freeze(frz3), .stall_count(cnt3)
  );

  // Output vector order: {pc_write, ifid_write, ifid_flush, ctrl_en, pipe_freeze}
  localparam logic [4:0] NRM = 5'b11010;
  localparam logic [4:0] STL = 5'b00000;
  localparam logic [4:0] BSY = 5'b00011;
  localparam logic [4:0] BRN = 5'b11100;
  localparam logic [4:0] RST = 5'b00100;

  typedef struct {
    string      tag;
    int         dut;
    logic [4:0] o;
    logic [3:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [4:0] got_o;
      logic [3:0] got_c;
      e = q.pop_front();
      if (e.dut == 1) begin
        got_o = {pcw1, ifw1, fl1, cen1, frz1};
        got_c = cnt1;
      end else begin
        got_o = {pcw3, ifw3, fl3, cen3, frz3};
        got_c = cnt3;
      end
      n_checks++;
      if (got_o !== e.o || got_c !== e.cnt) begin
        n_errors++;
        $display("FAIL %s lat%0d: got out=%b cnt=%0d, need out=%b cnt=%0d",
                 e.tag, e.dut, got_o, got_c, e.o, e.cnt);
      end
    end
  end

  task automatic step(input logic rn, input logic mr, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2,
                      input logic br, input logic busy, input logic clr,
                      input string tag,
                      input logic [4:0] e1, input int c1,
                      input logic [4:0] e3, input int c3);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rn; idex_memread = mr; idex_rd = rd;
    ifid_rs1 = rs1; ifid_use_rs1 = u1; ifid_rs2 = rs2; ifid_use_rs2 = u2;
    branch_taken = br; mem_busy = busy; perf_clr = clr;
    e.tag = tag; e.dut = 1; e.o = e1; e.cnt = 4'(c1); q.push_back(e);
    e.dut = 3; e.o = e3; e.cnt = 4'(c3); q.push_back(e);
  endtask

  initial begin
    //    rn mr rd  rs1 u1 rs2 u2 br bsy clr
    step(0, 0, 0,  0, 0, 0, 0, 0, 0, 0, "reset",      RST, 0, RST, 0);
    step(1, 0, 0,  0, 0, 0, 0, 0, 0, 0, "post_reset", NRM, 0, NRM, 0);
    // Load-use on rs1, then ID/EX becomes a bubble while IF/ID holds the user
    step(1, 1, 5,  5, 1, 0, 0, 0, 0, 0, "lu_rs1",     STL, 0, STL, 0);
    step(1, 0, 0,  5, 1, 0, 0, 0, 0, 0, "lu_b2",      NRM, 1, STL, 1);
    step(1, 0, 0,  5, 1, 0, 0, 0, 0, 0, "lu_b3",      NRM, 1, STL, 2);
    step(1, 0, 0,  5, 1, 0, 0, 0, 0, 0, "lu_done",    NRM, 1, NRM, 3);
    step(1, 0, 0,  0, 0, 0, 0, 0, 0, 1, "clr",        NRM, 1, NRM, 3);
    step(1, 0, 0,  0, 0, 0, 0, 0, 0, 0, "clr_done",   NRM, 0, NRM, 0);
    // x0 never stalls; unused rs2 never stalls
    step(1, 1, 0,  0, 1, 0, 1, 0, 0, 0, "x0",         NRM, 0, NRM, 0);
    step(1, 1, 7,  3, 1, 7, 0, 0, 0, 0, "rs2_unused", NRM, 0, NRM, 0);
    // Load-use on rs2 with memory busy mid-stall
    step(1, 1, 7,  3, 1, 7, 1, 0, 0, 0, "lu_rs2",     STL, 0, STL, 0);
    step(1, 0, 0,  3, 1, 7, 1, 0, 0, 0, "busy_b2",    NRM, 1, STL, 1);
    step(1, 0, 0,  3, 1, 7, 1, 0, 1, 0, "busy_1",     BSY, 1, BSY, 2);
    step(1, 0, 0,  3, 1, 7, 1, 0, 1, 0, "busy_2",     BSY, 2, BSY, 3);
    step(1, 0, 0,  3, 1, 7, 1, 0, 0, 0, "busy_b3",    NRM, 3, STL, 4);
    step(1, 0, 0,  3, 1, 7, 1, 0, 0, 0, "busy_done",  NRM, 3, NRM, 5);
    step(1, 0, 0,  0, 0, 0, 0, 0, 0, 1, "clr2",       NRM, 3, NRM, 5);
    // Branch beats a hazard in IDLE and aborts a pending stall
    step(1, 1, 5,  5, 1, 0, 0, 1, 0, 0, "br_hz",      BRN, 0, BRN, 0);
    step(1, 0, 0,  5, 1, 0, 0, 0, 0, 0, "br_after",   NRM, 0, NRM, 0);
    step(1, 1, 9,  9, 1, 0, 0, 0, 0, 0, "lu_pre_br",  STL, 0, STL, 0);
    step(1, 0, 0,  9, 1, 0, 0, 1, 0, 0, "br_abort",   BRN, 1, BRN, 1);
    step(1, 0, 0,  9, 1, 0, 0, 0, 0, 0, "abort_idle", NRM, 1, NRM, 1);
    step(1, 0, 0,  0, 0, 0, 0, 1, 1, 0, "busy_vs_br", BSY, 1, BSY, 1);
    // Saturation of the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      int c;
      c = (2 + i > 15) ? 15 : 2 + i;
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, "sat", BSY, c, BSY, c);
    end
    step(1, 0, 0,  0, 0, 0, 0, 0, 0, 0, "sat_hold",   NRM, 15, NRM, 15);
    step(1, 0, 0,  0, 0, 0, 0, 0, 0, 1, "sat_clr",    NRM, 15, NRM, 15);
    step(1, 0, 0,  0, 0, 0, 0, 0, 0, 0, "sat_zero",   NRM, 0, NRM, 0);
    // Reset in the middle of a multi-cycle stall
    step(1, 1, 4,  4, 1, 0, 0, 0, 0, 0, "lu_pre_rst", STL, 0, STL, 0);
    step(1, 0, 0,  4, 1, 0, 0, 0, 0, 0, "lu_in_stl",  NRM, 1, STL, 1);
    step(0, 0, 0,  4, 1, 0, 0, 0, 0, 0, "rst_mid",    RST, 0, RST, 0);
    step(1, 0, 0,  4, 1, 0, 0, 0, 0, 0, "rst_idle",   NRM, 0, NRM, 0);

    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending, need 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
